// File: rtl/confi_loader.sv
// confi_loader: snapshots a configuration vector on Start, writes it to registers 0..NUM_REGS-1,
// then optionally reads each register back and flags the first mismatching address.
module confi_loader #(
    parameter int NUM_REGS   = 10,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter bit VERIFY     = 1
) (
    input  logic                           CONFI_LOADER_Clk,
    input  logic                           CONFI_LOADER_Reset,
    input  logic                           CONFI_LOADER_Start,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] CONFI_LOADER_Src_Data,
    output logic [ADDR_WIDTH-1:0]          CONFI_LOADER_Addr,
    output logic [DATA_WIDTH-1:0]          CONFI_LOADER_Writedata,
    output logic                           CONFI_LOADER_We,
    output logic                           CONFI_LOADER_Re,
    input  logic [DATA_WIDTH-1:0]          CONFI_LOADER_Readdata,
    output logic                           CONFI_LOADER_Busy,
    output logic                           CONFI_LOADER_Done,
    output logic                           CONFI_LOADER_Error,
    output logic [ADDR_WIDTH-1:0]          CONFI_LOADER_Err_Addr
);
    typedef enum logic [2:0] {IDLE, WRITE, READ, CHECK, DONE} state_t;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_REGS - 1);
    state_t state, state_next;
    logic [ADDR_WIDTH-1:0] idx, idx_next, err_addr, err_addr_next;
    logic error, error_next;
    logic [DATA_WIDTH-1:0] shadow [NUM_REGS];
    logic accept, last;
    assign accept = state == IDLE && CONFI_LOADER_Start;
    assign last   = idx == LAST;
    always_ff @(posedge CONFI_LOADER_Clk or posedge CONFI_LOADER_Reset) begin
        if (CONFI_LOADER_Reset) begin
            state    <= IDLE;
            idx      <= '0;
            error    <= 1'b0;
            err_addr <= '0;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            error    <= error_next;
            err_addr <= err_addr_next;
        end
    end
    // The snapshot is taken only on the accepting edge, so later Src_Data changes cannot leak in.
    always_ff @(posedge CONFI_LOADER_Clk) begin
        if (accept)
            for (int i = 0; i < NUM_REGS; i++)
                shadow[i] <= CONFI_LOADER_Src_Data[i*DATA_WIDTH +: DATA_WIDTH];
    end
    always_comb begin
        state_next    = state;
        idx_next      = idx;
        error_next    = error;
        err_addr_next = err_addr;
        case (state)
            IDLE: if (CONFI_LOADER_Start) begin
                state_next    = WRITE;
                idx_next      = '0;
                error_next    = 1'b0;
                err_addr_next = '0;
            end
            WRITE: begin
                idx_next   = last ? '0 : idx + 1'b1;
                state_next = !last ? WRITE : VERIFY ? READ : DONE;
            end
            READ: state_next = CHECK;
            CHECK: begin
                if (CONFI_LOADER_Readdata != shadow[idx] && !error) begin
                    error_next    = 1'b1;
                    err_addr_next = idx;
                end
                idx_next   = last ? idx : idx + 1'b1;
                state_next = last ? DONE : READ;
            end
            default: state_next = IDLE;
        endcase
    end
    // Bus outputs depend only on registered state and idx.
    assign CONFI_LOADER_We        = state == WRITE;
    assign CONFI_LOADER_Re        = state == READ;
    assign CONFI_LOADER_Addr      = (state == WRITE || state == READ) ? idx : '0;
    assign CONFI_LOADER_Writedata = state == WRITE ? shadow[idx] : '0;
    assign CONFI_LOADER_Busy      = state != IDLE;
    assign CONFI_LOADER_Done      = state == DONE;
    assign CONFI_LOADER_Error     = error;
    assign CONFI_LOADER_Err_Addr  = err_addr;
endmodule

// File: tb/tb_confi_loader.sv
// tb_confi_loader: scoreboard bench; stimulus pushes expected bus events, monitors pop and compare.
module tb_confi_loader;
    typedef struct {int kind; logic [3:0] addr; logic [31:0] data; int cyc;} ev_t;
    logic clk = 0, rst = 1, start = 0, start0 = 0, corrupt = 0;
    logic [319:0] src;
    logic [3:0] addr1, eaddr1, addr0, eaddr0;
    logic [31:0] wd1, rd1, wd0, rd0;
    logic we1, re1, busy1, done1, err1, we0, re0, busy0, done0, err0;
    logic [31:0] mem1 [16];
    ev_t q1[$], q0[$];
    ev_t e1, e0;
    int k1, k0;
    int cyc = 0, tests = 0, fails = 0, c;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    confi_loader #(.VERIFY(1)) dut1 (
        .CONFI_LOADER_Clk(clk), .CONFI_LOADER_Reset(rst), .CONFI_LOADER_Start(start),
        .CONFI_LOADER_Src_Data(src), .CONFI_LOADER_Addr(addr1), .CONFI_LOADER_Writedata(wd1),
        .CONFI_LOADER_We(we1), .CONFI_LOADER_Re(re1), .CONFI_LOADER_Readdata(rd1),
        .CONFI_LOADER_Busy(busy1), .CONFI_LOADER_Done(done1), .CONFI_LOADER_Error(err1),
        .CONFI_LOADER_Err_Addr(eaddr1));

    confi_loader #(.VERIFY(0)) dut0 (
        .CONFI_LOADER_Clk(clk), .CONFI_LOADER_Reset(rst), .CONFI_LOADER_Start(start0),
        .CONFI_LOADER_Src_Data(src), .CONFI_LOADER_Addr(addr0), .CONFI_LOADER_Writedata(wd0),
        .CONFI_LOADER_We(we0), .CONFI_LOADER_Re(re0), .CONFI_LOADER_Readdata(rd0),
        .CONFI_LOADER_Busy(busy0), .CONFI_LOADER_Done(done0), .CONFI_LOADER_Error(err0),
        .CONFI_LOADER_Err_Addr(eaddr0));

    assign rd0 = 32'h0;

    // Slave: registered readback, optionally corrupting addresses 4 and 7.
    always @(posedge clk) begin
        if (we1) mem1[addr1] <= wd1;
        if (re1) rd1 <= mem1[addr1] ^ ((corrupt && (addr1 == 4 || addr1 == 7)) ? 32'h0000_00FF : 32'h0);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    task automatic set_src(input logic [31:0] base);
        for (int i = 0; i < 10; i++) src[i*32 +: 32] = base + i;
    endtask

    // Expected bus events for a run accepted at the edge ending cycle c0.
    task automatic push1(input int c0, input logic [31:0] base, input int nw, input bit full);
        for (int i = 0; i < nw; i++) q1.push_back('{0, 4'(i), base + i, c0 + 1 + i});
        if (full) begin
            for (int i = 0; i < 10; i++) q1.push_back('{1, 4'(i), 32'h0, c0 + 11 + 2*i});
            q1.push_back('{2, 4'h0, 32'h0, c0 + 31});
        end
    endtask

    task automatic go1(input logic [31:0] base, output int c0);
        @(negedge clk);
        c0 = cyc;
        push1(c0, base, 10, 1);
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    always @(negedge clk) if (!rst) begin
        if (we1 && re1) begin tests++; fails++; $display("FAIL v1_we_re_both: got 1 expected 0"); end
        if (we1 || re1 || done1) begin
            k1 = we1 ? 0 : re1 ? 1 : 2;
            tests++;
            if (q1.size() == 0) begin
                fails++;
                $display("FAIL v1_event: got unexpected kind %0d addr %0d at cycle %0d, expected none", k1, addr1, cyc);
            end else begin
                e1 = q1.pop_front();
                if (e1.kind != k1 || e1.addr != addr1 || e1.data != wd1 || e1.cyc != cyc) begin
                    fails++;
                    $display("FAIL v1_event: got kind %0d addr %0d data %0h cycle %0d, expected kind %0d addr %0d data %0h cycle %0d",
                             k1, addr1, wd1, cyc, e1.kind, e1.addr, e1.data, e1.cyc);
                end
            end
        end
    end

    always @(negedge clk) if (!rst) begin
        if (we0 || re0 || done0) begin
            k0 = we0 ? 0 : re0 ? 1 : 2;
            tests++;
            if (q0.size() == 0) begin
                fails++;
                $display("FAIL v0_event: got unexpected kind %0d addr %0d at cycle %0d, expected none", k0, addr0, cyc);
            end else begin
                e0 = q0.pop_front();
                if (e0.kind != k0 || e0.addr != addr0 || e0.data != wd0 || e0.cyc != cyc) begin
                    fails++;
                    $display("FAIL v0_event: got kind %0d addr %0d data %0h cycle %0d, expected kind %0d addr %0d data %0h cycle %0d",
                             k0, addr0, wd0, cyc, e0.kind, e0.addr, e0.data, e0.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        set_src(32'h100);
        #1;
        chk("reset_outputs", {addr1, wd1, we1, re1, busy1, done1, err1, eaddr1}, 64'h0);
        repeat (3) @(negedge clk);
        rst = 0;

        // Nominal load
        go1(32'h100, c);
        wait_to(c + 32);
        chk("nominal_error", {err1, eaddr1}, 0);
        chk("nominal_busy_after", busy1, 0);
        for (int i = 0; i < 10; i++) chk($sformatf("slave_mem%0d", i), mem1[i], 32'h100 + i);

        // Readback fault at addresses 4 and 7
        corrupt = 1;
        go1(32'h100, c);
        wait_to(c + 32);
        chk("fault_error", err1, 1);
        chk("fault_err_addr", eaddr1, 4);
        repeat (3) @(negedge clk);
        chk("fault_error_held", {err1, eaddr1}, {1'b1, 4'd4});
        corrupt = 0;
        go1(32'h100, c);
        chk("restart_clears_error", {err1, eaddr1}, 0);
        wait_to(c + 32);
        chk("restart_error_after", err1, 0);

        // VERIFY=0 instance
        @(negedge clk);
        c = cyc;
        for (int i = 0; i < 10; i++) q0.push_back('{0, 4'(i), 32'h100 + i, c + 1 + i});
        q0.push_back('{2, 4'h0, 32'h0, c + 11});
        start0 = 1;
        @(negedge clk);
        start0 = 0;
        wait_to(c + 11);
        chk("v0_busy_done_cycle", busy0, 1);
        @(negedge clk);
        chk("v0_busy_cycle12", busy0, 0);

        // Snapshot and ignored Start
        go1(32'h100, c);
        wait_to(c + 3);
        src = '1;
        start = 1;
        @(negedge clk);
        start = 0;
        wait_to(c + 32);
        chk("snapshot_mem5", mem1[5], 32'h105);
        set_src(32'h100);

        // Reset mid-run
        @(negedge clk);
        c = cyc;
        push1(c, 32'h100, 4, 0);
        start = 1;
        @(negedge clk);
        start = 0;
        wait_to(c + 4);
        @(posedge clk);
        #2 rst = 1;
        #1;
        chk("midrun_reset_outputs", {addr1, wd1, we1, re1, busy1, done1, err1, eaddr1}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        set_src(32'h300);
        go1(32'h300, c);
        wait_to(c + 32);
        chk("after_reset_mem0", mem1[0], 32'h300);

        // Back-to-back: Start in DONE ignored, next cycle accepted
        set_src(32'h100);
        go1(32'h100, c);
        wait_to(c + 31);
        set_src(32'h200);
        start = 1;
        @(negedge clk);
        push1(c + 32, 32'h200, 10, 1);
        @(negedge clk);
        start = 0;
        wait_to(c + 32 + 32);
        chk("b2b_mem9", mem1[9], 32'h209);
        chk("b2b_error", err1, 0);

        repeat (5) @(negedge clk);
        chk("q1_drained", q1.size(), 0);
        chk("q0_drained", q0.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/confi_loader.md
# confi_loader

- Bus initiator for the accelerator's memory-mapped configuration register block.
- On a start pulse it snapshots a full configuration vector and writes one word per register, addresses 0..NUM_REGS-1.
- Optionally it reads every register back and compares it against the snapshot, then reports done, plus a sticky error with the first mismatching address.
- Sits between the host-side sequencer and the configuration registers, so a whole layer setup is loaded without per-register CPU traffic.

## Interface
- NUM_REGS, 10, number of configuration registers loaded (addresses 0..NUM_REGS-1); must be ≤ 2^ADDR_WIDTH.
- ADDR_WIDTH, 4, register address width.
- DATA_WIDTH, 32, register data width.
- VERIFY, 1, 1 = readback-and-compare phase enabled; 0 = write only.
- CONFI_LOADER_Clk  in  1  single clock; everything is sampled on the rising edge.
- CONFI_LOADER_Reset  in  1  asynchronous, active-high reset.
- CONFI_LOADER_Start  in  1  start request; accepted only in IDLE.
- CONFI_LOADER_Src_Data  in  NUM_REGS*DATA_WIDTH  configuration vector; slot i is at bits [i*DATA_WIDTH +: DATA_WIDTH].
- CONFI_LOADER_Addr  out  ADDR_WIDTH  register address driven to the slave.
- CONFI_LOADER_Writedata  out  DATA_WIDTH  write data to the slave.
- CONFI_LOADER_We  out  1  write strobe, one cycle per register.
- CONFI_LOADER_Re  out  1  read strobe, one cycle per register.
- CONFI_LOADER_Readdata  in  DATA_WIDTH  slave read data; registered by the slave, valid the cycle after Re.
- CONFI_LOADER_Busy  out  1  high whenever state ≠ IDLE.
- CONFI_LOADER_Done  out  1  one-cycle completion pulse.
- CONFI_LOADER_Error  out  1  sticky readback mismatch flag.
- CONFI_LOADER_Err_Addr  out  ADDR_WIDTH  address of the first mismatch.

## Operation
States are IDLE, WRITE, READ, CHECK and DONE. An index register idx (width ADDR_WIDTH) is used, plus a shadow buffer of NUM_REGS×DATA_WIDTH.

- **IDLE:**
  - Start=1 → capture Src_Data into the shadow, set idx=0, clear Error and Err_Addr, go to WRITE.
  - Start=0 → stay.
- **WRITE:**
  - Drive We=1, Addr=idx, Writedata=shadow[idx].
  - idx<NUM_REGS-1 → idx+1, stay.
  - Otherwise → idx=0 and go to READ if VERIFY=1, else DONE.
- **READ:** drive Re=1, Addr=idx; go to CHECK.
- **CHECK:**
  - Compare Readdata with shadow[idx].
  - On mismatch with Error=0 → Error=1, Err_Addr=idx. Later mismatches do not overwrite Err_Addr.
  - idx<NUM_REGS-1 → idx+1, go to READ; otherwise go to DONE.
- **DONE:** Done=1; go to IDLE.

Output and boundary rules:
- When not in WRITE, We=0 and Writedata=0.
- When not in READ, Re=0.
- When in neither WRITE nor READ, Addr=0.
- Bus outputs are decoded from registered state and idx only; there is no combinational path from Start or Readdata to any output.
- Start while Busy (including in DONE) is ignored. No queuing.
- Src_Data changes after the accepting edge have no effect on the current run.
- Error and Err_Addr hold their values after DONE until the next accepted Start.
- We and Re are never high in the same cycle.

## Timing
- Reset values: Addr=0, Writedata=0, We=0, Re=0, Busy=0, Done=0, Error=0, Err_Addr=0, state=IDLE, idx=0.
- Reset is asynchronous: outputs reach their reset values without waiting for a clock edge, including mid-run. The shadow buffer need not be reset.
- A run stopped by reset is not resumed. Registers already written in the slave keep their contents (subject to the slave's own reset).
- Cycle numbering: Start sampled high at the edge ending cycle 0.
- Write phase: WRITE occupies cycles 1..NUM_REGS, one register per cycle in ascending order.
- VERIFY=1:
  - READ and CHECK alternate over cycles NUM_REGS+1 .. 3·NUM_REGS.
  - Readdata is sampled in CHECK, one cycle after its Re.
  - DONE is in cycle 3·NUM_REGS+1 (cycle 31 for defaults).
- VERIFY=0: DONE is in cycle NUM_REGS+1 (cycle 11).
- Busy is high from cycle 1 through the DONE cycle inclusive.
- The earliest next accepted Start is sampled in the first IDLE cycle after DONE.

## Test plan
- **Nominal load:** reset, Src_Data slot i = 0x100+i, Start for one cycle, slave model with 1-cycle registered readback → We high in cycles 1..10 with Addr 0..9 and Writedata 0x100..0x109; Re pulses at addresses 0..9 on alternate cycles; Done in cycle 31 only; Error=0; slave holds 0x100+i.
- **Readback fault:** slave model corrupts reads of addresses 4 and 7 → Error=1, Err_Addr=4 after the run; Done still in cycle 31; next Start clears Error during cycle 1.
- **VERIFY=0:** same stimulus as the nominal load → Re never asserted; Done in cycle 11; Busy low from cycle 12.
- **Snapshot and ignored Start:** change Src_Data to 0xFFFFFFFF everywhere and pulse Start in cycle 3 → writes remain 0x100+i; no restart; Done timing unchanged.
- **Reset mid-run:** assert Reset during cycle 5 → all outputs 0 immediately and state IDLE; after release a Start performs the full 10-write sequence from address 0.
- **Back-to-back:** Start high in the DONE cycle → ignored; Start in the following cycle → accepted, new run with identical timing.
